// File: rtl/cpu_mem_pkg.sv
// Shared memory-access definitions for the CPU load/store path.
package cpu_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE,
        S_ERR
    } load_state_t;

    function automatic logic [2:0] size_to_bytes(input logic [1:0] sz);
        case (sz)
            SZ_HALF: size_to_bytes = 3'd2;
            SZ_WORD: size_to_bytes = 3'd4;
            default: size_to_bytes = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/load_unit_if.sv
// Request/response bundle between the CPU datapath and the load unit.
interface load_unit_if #(
    parameter int ADDR_W = 32
) ();
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    logic              sign_ext;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       data;

    modport master (
        output req, addr, size, sign_ext,
        input  busy, done, err, data
    );

    modport slave (
        input  req, addr, size, sign_ext,
        output busy, done, err, data
    );
endinterface

// File: rtl/load_extend.sv
// Sign/zero extension of a little-endian load buffer to a full 32-bit word.
module load_extend
    import cpu_mem_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] ext
);
    always_comb begin
        ext = raw;
        case (size)
            SZ_BYTE: ext = {{24{sign_ext & raw[7]}}, raw[7:0]};
            SZ_HALF: ext = {{16{sign_ext & raw[15]}}, raw[15:0]};
            default: ext = raw;
        endcase
    end
endmodule

// File: rtl/load_unit.sv
// Multicycle byte-serial load controller: reads 1/2/4 bytes from a byte-wide
// synchronous memory and assembles an extended 32-bit word.
module load_unit
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    load_unit_if.slave        lu,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata
);
    load_state_t state, next_state;

    logic [1:0]  sz_q;
    logic        sx_q;
    logic [1:0]  k;
    logic [1:0]  last_k;
    logic        cap_en;
    logic [1:0]  cap_lane;
    logic [31:0] buffer;
    logic [31:0] buf_next;
    logic [31:0] ext_word;
    logic [31:0] data_q;
    logic        illegal;

    assign illegal = (lu.size == 2'b11)
                   || (lu.size == SZ_HALF && lu.addr[0])
                   || (lu.size == SZ_WORD && lu.addr[1:0] != 2'b00);

    assign last_k = 2'(size_to_bytes(sz_q) - 3'd1);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (lu.req) next_state = illegal ? S_ERR : S_ISSUE;
            S_ISSUE: if (k == last_k) next_state = S_DRAIN;
            S_DRAIN: next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            S_ERR:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        lu.busy = (state != S_IDLE);
        lu.done = (state == S_DONE) || (state == S_ERR);
        lu.err  = (state == S_ERR);
    end

    assign lu.data = data_q;

    // Byte from the previous ISSUE cycle merged in-flight, so DONE can be
    // loaded on the same edge that captures the final byte.
    always_comb begin
        buf_next = buffer;
        buf_next[{cap_lane, 3'b000} +: 8] = mem_rdata;
    end

    load_extend u_extend (
        .raw      (buf_next),
        .size     (sz_q),
        .sign_ext (sx_q),
        .ext      (ext_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sz_q     <= '0;
            sx_q     <= 1'b0;
            k        <= '0;
            cap_en   <= 1'b0;
            cap_lane <= '0;
            buffer   <= '0;
            data_q   <= '0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
        end else begin
            mem_rd   <= (next_state == S_ISSUE);
            cap_en   <= (state == S_ISSUE);
            cap_lane <= k;
            case (state)
                S_IDLE: if (lu.req) begin
                    sz_q     <= lu.size;
                    sx_q     <= lu.sign_ext;
                    k        <= '0;
                    mem_addr <= lu.addr;
                end
                S_ISSUE: begin
                    k        <= k + 2'd1;
                    mem_addr <= mem_addr + ADDR_W'(1);
                end
                default: ;
            endcase
            if (cap_en)             buffer <= buf_next;
            if (state == S_DRAIN)   data_q <= ext_word;
        end
    end
endmodule

// File: doc/load_unit.md
# load_unit

Multicycle memory read controller for the CPU datapath. It takes a load request with a byte address and access size, reads the bytes little-endian from a byte-wide synchronous memory, and assembles them into a 32-bit word. Byte and halfword loads are sign- or zero-extended. It is the read-side counterpart of the datapath's write-enabled 32-bit registers: its `data` output feeds the memory data register, and its `done` pulse drives that register's enable.

## Interface
Parameters:
- `ADDR_W`, default 32: byte address width.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: clock; all state changes on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `req`, in, 1: load request; sampled only in IDLE.
- `addr`, in, ADDR_W: byte address of the load, sampled with `req`.
- `size`, in, 2: access size; 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `sign_ext`, in, 1: 1 = sign-extend, 0 = zero-extend; ignored for word loads.
- `busy`, out, 1: 1 in every state except IDLE.
- `done`, out, 1: one-cycle pulse marking completion, success or error.
- `err`, out, 1: valid while `done`=1; misaligned or illegal request.
- `data`, out, 32: loaded word; registered; holds its value until the next successful completion.
- `mem_rd`, out, 1: memory read strobe.
- `mem_addr`, out, ADDR_W: memory byte address; only meaningful while `mem_rd`=1.
- `mem_rdata`, in, 8: memory read data; valid exactly one cycle after the cycle where `mem_rd`=1.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE, ERR.
- **IDLE.** On `req`=1, the block latches `addr`, `size` and `sign_ext`, then checks the request.
  - Illegal if `size`=11, or half with `addr[0]`=1, or word with `addr[1:0]`≠00. An illegal request goes to ERR.
  - Otherwise the byte count N is set to 1, 2 or 4, the counter k is cleared to 0, and the next state is ISSUE.
- **ISSUE.**
  - Outputs: `mem_rd`=1 and `mem_addr` = base + k.
  - k increments each cycle.
  - After the cycle with k = N−1, the next state is DRAIN.
- **Byte capture.** In every cycle following an ISSUE cycle, `mem_rdata` is stored into buffer byte lane k_prev, where k_prev is the k of the preceding ISSUE cycle. Lane 0 is the LSB (little-endian).
- **DRAIN.** Captures the final byte. `mem_rd`=0. Next state is DONE.
- **DONE.**
  - `done`=1, `err`=0.
  - `data` is loaded on entry with the extended buffer:
    - byte: lane 0 extended from bit 7;
    - half: lanes 1:0 extended from bit 15;
    - word: all four lanes unchanged.
  - Next state is IDLE.
- **ERR.** `done`=1, `err`=1, no memory access, `data` unchanged. Next state is IDLE.
- **Back-to-back requests.** A `req` held high during the DONE or ERR cycle is ignored. It is accepted in the following IDLE cycle.
- **Requests while busy.** `req` is ignored whenever `busy`=1; inputs are not re-latched.
- **Address arithmetic.** base + k wraps modulo 2^ADDR_W. Aligned accesses never cross the wrap point.
- **Reset** (any state, including mid-transfer):
  - state returns to IDLE; k and the buffer are cleared;
  - `data`=0, `done`=0, `err`=0, `busy`=0, `mem_rd`=0, `mem_addr`=0;
  - a transfer interrupted by reset produces no `done`.

## Timing
- Request accepted at edge T0.
- ISSUE occupies cycles T1..TN; DRAIN is cycle TN+1; DONE (`done`=1, `data` valid) is cycle TN+2.
- Latency from `req` to `done`: byte 3 cycles, half 4, word 6.
- Illegal request: ERR in cycle T1, latency 1 cycle.
- Minimum request spacing: N+3 cycles for a successful load, 2 cycles for an error.
- `mem_addr` and `mem_rd` are registered outputs. No combinational path from `mem_rdata` to any output.

## Structure
- Shared package `cpu_mem_pkg`:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - the state enum `load_state_t`;
  - function `size_to_bytes`.
- One sub-module, `load_extend` (combinational): takes a 32-bit buffer, size and sign_ext, and returns the extended word. It is shared with any later store/load-forwarding logic.

## Test plan
- Word load at 0x100, memory bytes 78,56,34,12 -> `mem_addr` 0x100..0x103 in T1..T4, `done` at T6, `data`=0x12345678, `err`=0.
- Byte load at 0x203 of 0x80 -> with `sign_ext`=1, `data`=0xFFFFFF80; with `sign_ext`=0, `data`=0x00000080; `done` at T3.
- Half load at 0x101 -> `err`=1 and `done`=1 at T1, `mem_rd` never asserted, `data` keeps its previous value. Same for `size`=11.
- Half load at 0x0FE of bytes 34,92 with `sign_ext`=1 -> `data`=0xFFFF9234 at T4. A `req` asserted during T1..T4 is ignored (no extra `mem_rd`).
- `reset` asserted in T2 of a word load -> next cycle all outputs are 0, no `done`. A new byte load then completes normally in 3 cycles.
- `req` held high continuously for two word loads -> second accepted in the cycle after DONE, two `done` pulses 7 cycles apart.
